// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a carry flip-flop add two WIDTH-bit
// operands LSB-first, one bit per clock, then pulse done with {cout, sum} valid.
module serial_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] sh_a_q, sh_b_q, sum_q;
    logic [CW-1:0]    count_q;
    logic             carry_q, cout_q, busy_q, done_q;

    logic             bit_s_d, carry_d;
    logic [WIDTH-1:0] sh_a_d, sh_b_d, sum_d;

    // NOTE: every always_comb output gets a default before any partial
    // overwrite, so no path leaves a bit unassigned and no latch is inferred.
    always_comb begin
        bit_s_d          = sh_a_q[0] ^ sh_b_q[0] ^ carry_q;
        carry_d          = (sh_a_q[0] & sh_b_q[0]) | (sh_a_q[0] & carry_q)
                         | (sh_b_q[0] & carry_q);
        sh_a_d           = sh_a_q >> 1;
        sh_b_d           = sh_b_q >> 1;
        sum_d            = sum_q >> 1;
        sum_d[WIDTH-1]   = bit_s_d;
    end

    // NOTE: all state lives in this one clocked block and uses non-blocking
    // assignments, so every register sees the pre-edge value of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sh_a_q  <= '0;
            sh_b_q  <= '0;
            sum_q   <= '0;
            count_q <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        sh_a_q  <= a;
                        sh_b_q  <= b;
                        carry_q <= 1'b0;
                        count_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    sh_a_q  <= sh_a_d;
                    sh_b_q  <= sh_b_d;
                    sum_q   <= sum_d;
                    carry_q <= carry_d;
                    count_q <= count_q + CW'(1);
                    if (count_q == LAST) begin
                        cout_q  <= carry_d;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed vector table at WIDTH=4,
// abort/ignore corner sequences, and exhaustive sweeps at WIDTH=4 and WIDTH=1.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start4, start1;
    logic [3:0] a4, b4, sum4;
    logic [0:0] a1, b1, sum1;
    logic       busy4, done4, cout4, busy1, done1, cout1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] sum;
        logic       cout;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Start an operation on the 4-bit DUT; lat counts edges after the start
    // edge until done is seen (bounded).
    task automatic run4(input logic [3:0] ta, input logic [3:0] tb_v,
                        output logic [3:0] s, output logic c, output int lat);
        a4     = ta;
        b4     = tb_v;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        lat    = 0;
        while (!done4 && lat < 20) begin
            tick();
            lat++;
        end
        s = sum4;
        c = cout4;
        tick();
    endtask

    task automatic run1(input logic [0:0] ta, input logic [0:0] tb_v,
                        output logic [0:0] s, output logic c, output int lat);
        a1     = ta;
        b1     = tb_v;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        lat    = 0;
        while (!done1 && lat < 10) begin
            tick();
            lat++;
        end
        s = sum1;
        c = cout1;
        tick();
    endtask

    initial begin
        vec_t       vecs[7];
        logic [3:0] s;
        logic [0:0] s1;
        logic       c;
        int         lat;
        int         pulses;

        vecs[0] = '{4'd5, 4'd3, 4'd8, 1'b0};
        vecs[1] = '{4'd7, 4'd9, 4'd0, 1'b1};
        vecs[2] = '{4'hF, 4'hF, 4'hE, 1'b1};
        vecs[3] = '{4'd0, 4'd0, 4'd0, 1'b0};
        vecs[4] = '{4'd8, 4'd8, 4'd0, 1'b1};
        vecs[5] = '{4'd1, 4'hF, 4'd0, 1'b1};
        vecs[6] = '{4'hA, 4'd5, 4'hF, 1'b0};

        rst = 1'b1; start4 = 1'b0; start1 = 1'b0;
        a4 = '0; b4 = '0; a1 = '0; b1 = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("reset_busy4", busy4, 0);
        check("reset_done4", done4, 0);
        check("reset_sum4", sum4, 0);
        check("reset_cout4", cout4, 0);
        check("reset_busy1", busy1, 0);
        check("reset_sum1", {cout1, sum1}, 0);

        // First vector also checks the cycle-by-cycle timeline.
        a4 = 4'd5; b4 = 4'd3; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        check("timeline_busy_after_start", busy4, 1);
        check("timeline_no_early_done", done4, 0);
        tick(); tick(); tick();
        check("timeline_done_not_at_k3", done4, 0);
        tick();
        check("timeline_done_at_k4", done4, 1);
        check("timeline_busy_in_done", busy4, 1);
        tick();
        check("timeline_done_one_cycle", done4, 0);
        check("timeline_busy_cleared", busy4, 0);
        check("timeline_sum_holds", {cout4, sum4}, 5'd8);

        for (int i = 0; i < 7; i++) begin
            run4(vecs[i].a, vecs[i].b, s, c, lat);
            check($sformatf("vec%0d_latency", i), lat, 4);
            check($sformatf("vec%0d_sum", i), s, vecs[i].sum);
            check($sformatf("vec%0d_cout", i), c, vecs[i].cout);
        end
        tick();
        check("hold_after_idle", {cout4, sum4}, {1'b0, 4'hF});

        // Extra start and operand changes during SHIFT must be ignored.
        a4 = 4'd5; b4 = 4'd3; start4 = 1'b1;
        tick();
        a4 = 4'hF; b4 = 4'hF;
        tick();
        start4 = 1'b0;
        a4 = 4'd1; b4 = 4'd2;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            if (done4) begin
                pulses++;
                check("ignore_sum", {cout4, sum4}, 5'd8);
            end
            tick();
        end
        check("ignore_one_pulse", pulses, 1);

        // Reset in the second SHIFT cycle aborts without a done pulse.
        a4 = 4'd5; b4 = 4'd3; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", busy4, 0);
        check("abort_sum", {cout4, sum4}, 0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (done4) pulses++;
            tick();
        end
        check("abort_no_done", pulses, 0);
        run4(4'd6, 4'd7, s, c, lat);
        check("after_abort_result", {c, s}, 5'd13);

        // rst and start on the same edge: rst wins.
        rst = 1'b1; start4 = 1'b1; a4 = 4'd3; b4 = 4'd3;
        tick();
        rst = 1'b0; start4 = 1'b0;
        check("rst_beats_start_busy", busy4, 0);
        tick();
        check("rst_beats_start_idle", busy4, 0);

        for (int i = 0; i < 256; i++) begin
            logic [3:0] ea, eb;
            ea = 4'(i >> 4);
            eb = 4'(i);
            run4(ea, eb, s, c, lat);
            check($sformatf("exh4_%0h_%0h", ea, eb), {lat[3:0], c, s}, {4'd4, 5'(ea) + 5'(eb)});
        end

        for (int i = 0; i < 4; i++) begin
            logic [0:0] ea, eb;
            ea = 1'(i >> 1);
            eb = 1'(i);
            run1(ea, eb, s1, c, lat);
            check($sformatf("exh1_%0d_%0d", ea, eb), {lat[3:0], c, s1}, {4'd1, 2'(ea) + 2'(eb)});
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
